// File: rtl/typedef_pkg.sv
// typedef_pkg: shared fetch-path types and sizing constants
package typedef_pkg;
    localparam int FETCHQ_DEPTH = 8;
    localparam int FETCH_ADDR_W = 32;
    localparam int FETCH_DATA_W = 32;
    typedef struct packed {
        logic [FETCH_DATA_W-1:0] data;
        logic [FETCH_ADDR_W-1:0] addr;
        logic                    valid;
    } fetch_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: circular instruction queue taking 2-wide fetch groups and presenting head/head+1 to decode
// ports: clk/rst (sync, active-high); flush empties the queue; enq_valid + instruction_0/1 offer a group,
// accepted only while enq_ready; deq_0/deq_1 show head and head+1; deq_count retires 0..2 entries;
// count is occupancy; underflow_err is sticky when decode retires more than is held.
module fetch_queue
    import typedef_pkg::*;
#(
    parameter int DEPTH      = FETCHQ_DEPTH,
    parameter int ADDR_WIDTH = FETCH_ADDR_W,
    parameter int DATA_WIDTH = FETCH_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     enq_valid,
    input  fetch_t                   instruction_0,
    input  fetch_t                   instruction_1,
    output logic                     enq_ready,
    output fetch_t                   deq_0,
    output fetch_t                   deq_1,
    input  logic [1:0]               deq_count,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     underflow_err
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    logic [DATA_WIDTH-1:0] data_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
    logic [PW-1:0] head, tail, head_1, tail_1;
    logic [1:0] n_enq, n_deq;
    logic accept, over_deq;
    always_comb begin
        enq_ready = count <= CW'(DEPTH - 2);
        accept    = enq_valid && enq_ready && !flush;
        // an invalid instruction_0 drops the whole group, including instruction_1
        n_enq     = !accept || !instruction_0.valid ? 2'd0 : instruction_1.valid ? 2'd2 : 2'd1;
        over_deq  = CW'(deq_count) > count;
        // when over-dequeuing, count is below 3 so its low bits are the whole value
        n_deq     = over_deq ? count[1:0] : deq_count;
        head_1    = head + PW'(1);
        tail_1    = tail + PW'(1);
        deq_0     = count >= CW'(1) ? fetch_t'{data: data_mem[head], addr: addr_mem[head], valid: 1'b1}
                                    : fetch_t'{data: DATA_WIDTH'(0), addr: ADDR_WIDTH'(0), valid: 1'b0};
        deq_1     = count >= CW'(2) ? fetch_t'{data: data_mem[head_1], addr: addr_mem[head_1], valid: 1'b1}
                                    : fetch_t'{data: DATA_WIDTH'(0), addr: ADDR_WIDTH'(0), valid: 1'b0};
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            head          <= '0;
            tail          <= '0;
            count         <= '0;
            underflow_err <= 1'b0;
        end else begin
            if (over_deq)
                underflow_err <= 1'b1;
            if (flush) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + PW'(n_deq);
                tail  <= tail + PW'(n_enq);
                count <= count + CW'(n_enq) - CW'(n_deq);
            end
        end
    end
    // storage is unreset: only entries inside count are ever shown
    always_ff @(posedge clk) begin
        if (n_enq != 2'd0) begin
            data_mem[tail] <= instruction_0.data;
            addr_mem[tail] <= instruction_0.addr;
        end
        if (n_enq == 2'd2) begin
            data_mem[tail_1] <= instruction_1.data;
            addr_mem[tail_1] <= instruction_1.addr;
        end
    end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed vector bench for fetch_queue
module tb_fetch_queue;
    import typedef_pkg::*;
    typedef struct {
        logic        rst, flush, ev, v0;
        logic [31:0] a0;
        logic        v1;
        logic [31:0] a1;
        logic [1:0]  dq;
        int          c;
        logic        rdy, e0v;
        logic [31:0] e0a;
        logic        e1v;
        logic [31:0] e1a;
        logic        uf;
    } vec_t;

    logic clk = 0, rst = 1, flush = 0, enq_valid = 0, enq_ready, underflow_err;
    fetch_t instruction_0 = '0, instruction_1 = '0, deq_0, deq_1;
    logic [1:0] deq_count = 0;
    logic [3:0] count;
    int nvec = 0, errs = 0;
    vec_t vq[$];

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk(clk), .rst(rst), .flush(flush), .enq_valid(enq_valid),
        .instruction_0(instruction_0), .instruction_1(instruction_1),
        .enq_ready(enq_ready), .deq_0(deq_0), .deq_1(deq_1),
        .deq_count(deq_count), .count(count), .underflow_err(underflow_err)
    );

    function automatic vec_t mk(logic r, logic f, logic ev, logic v0, logic [31:0] a0, logic v1, logic [31:0] a1,
                                logic [1:0] dq, int c, logic rdy, logic e0v, logic [31:0] e0a,
                                logic e1v, logic [31:0] e1a, logic uf);
        vec_t v;
        v.rst = r; v.flush = f; v.ev = ev; v.v0 = v0; v.a0 = a0; v.v1 = v1; v.a1 = a1; v.dq = dq;
        v.c = c; v.rdy = rdy; v.e0v = e0v; v.e0a = e0a; v.e1v = e1v; v.e1a = e1a; v.uf = uf;
        return v;
    endfunction

    task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
        if (act !== exp) begin
            errs++;
            $display("FAIL %s vec=%0d got=0x%0h want=0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(logic r, logic f, logic ev, logic v0, logic [31:0] a0, logic v1, logic [31:0] a1, logic [1:0] dq);
        rst = r; flush = f; enq_valid = ev; deq_count = dq;
        instruction_0 = '{data: ~a0, addr: a0, valid: v0};
        instruction_1 = '{data: ~a1, addr: a1, valid: v1};
    endtask

    task automatic check_outs(int idx, int c, logic rdy, logic e0v, logic [31:0] e0a, logic e1v, logic [31:0] e1a, logic uf);
        chk("count", idx, 32'(count), 32'(c));
        chk("enq_ready", idx, 32'(enq_ready), 32'(rdy));
        chk("deq0_valid", idx, 32'(deq_0.valid), 32'(e0v));
        chk("deq0_addr", idx, deq_0.addr, e0v ? e0a : 32'h0);
        chk("deq0_data", idx, deq_0.data, e0v ? ~e0a : 32'h0);
        chk("deq1_valid", idx, 32'(deq_1.valid), 32'(e1v));
        chk("deq1_addr", idx, deq_1.addr, e1v ? e1a : 32'h0);
        chk("deq1_data", idx, deq_1.data, e1v ? ~e1a : 32'h0);
        chk("underflow_err", idx, 32'(underflow_err), 32'(uf));
    endtask

    initial begin
        // fill to full, ignored group, wrap reads, simultaneous enq/deq
        vq.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0,0,0,0,0));
        vq.push_back(mk(0,0,1,1,'h00,1,'h04,0, 2,1,1,'h00,1,'h04,0));
        vq.push_back(mk(0,0,1,1,'h08,1,'h0C,0, 4,1,1,'h00,1,'h04,0));
        vq.push_back(mk(0,0,1,1,'h10,1,'h14,0, 6,1,1,'h00,1,'h04,0));
        vq.push_back(mk(0,0,1,1,'h18,1,'h1C,0, 8,0,1,'h00,1,'h04,0));
        vq.push_back(mk(0,0,1,1,'h20,1,'h24,0, 8,0,1,'h00,1,'h04,0));
        vq.push_back(mk(0,0,0,0,0,0,0,2,       6,1,1,'h08,1,'h0C,0));
        vq.push_back(mk(0,0,1,1,'h20,1,'h24,2, 6,1,1,'h10,1,'h14,0));
        vq.push_back(mk(0,0,0,0,0,0,0,1,       5,1,1,'h14,1,'h18,0));
        vq.push_back(mk(0,0,1,1,'h28,1,'h2C,2, 5,1,1,'h1C,1,'h20,0));
        // partial groups, dropped group, group written at indices 7 and 0
        vq.push_back(mk(1,0,0,0,0,0,0,0, 0,1,0,0,0,0,0));
        vq.push_back(mk(0,0,1,1,'h100,1,'h104,0,    2,1,1,'h100,1,'h104,0));
        vq.push_back(mk(0,0,1,1,'h108,0,'hDEAD,0,   3,1,1,'h100,1,'h104,0));
        vq.push_back(mk(0,0,1,1,'h10C,0,'hDEAD,0,   4,1,1,'h100,1,'h104,0));
        vq.push_back(mk(0,0,1,0,'hBEEF,1,'h110,0,   4,1,1,'h100,1,'h104,0));
        vq.push_back(mk(0,0,1,1,'h110,1,'h114,0,    6,1,1,'h100,1,'h104,0));
        vq.push_back(mk(0,0,1,1,'h118,0,0,0,        7,0,1,'h100,1,'h104,0));
        vq.push_back(mk(0,0,0,0,0,0,0,2,            5,1,1,'h108,1,'h10C,0));
        vq.push_back(mk(0,0,1,1,'h11C,1,'h120,0,    7,0,1,'h108,1,'h10C,0));
        vq.push_back(mk(0,0,0,0,0,0,0,2,            5,1,1,'h110,1,'h114,0));
        vq.push_back(mk(0,0,0,0,0,0,0,2,            3,1,1,'h118,1,'h11C,0));
        vq.push_back(mk(0,0,0,0,0,0,0,2,            1,1,1,'h120,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,1,            0,1,0,0,0,0,0));
        // flush priority, sticky underflow, reset mid-operation
        vq.push_back(mk(0,0,1,1,'h200,1,'h204,0, 2,1,1,'h200,1,'h204,0));
        vq.push_back(mk(0,0,1,1,'h208,1,'h20C,0, 4,1,1,'h200,1,'h204,0));
        vq.push_back(mk(0,0,1,1,'h210,1,'h214,0, 6,1,1,'h200,1,'h204,0));
        vq.push_back(mk(0,1,1,1,'h218,1,'h21C,1, 0,1,0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,1,         0,1,0,0,0,0,1));
        vq.push_back(mk(0,0,1,1,'h300,1,'h304,0, 2,1,1,'h300,1,'h304,1));
        vq.push_back(mk(0,1,0,0,0,0,0,0,         0,1,0,0,0,0,1));
        vq.push_back(mk(1,0,0,0,0,0,0,0,         0,1,0,0,0,0,0));
        vq.push_back(mk(0,0,1,1,'h400,1,'h404,0, 2,1,1,'h400,1,'h404,0));
        vq.push_back(mk(1,0,1,1,'h408,1,'h40C,1, 0,1,0,0,0,0,0));
        vq.push_back(mk(0,0,1,1,'h410,1,'h414,0, 2,1,1,'h410,1,'h414,0));
        vq.push_back(mk(0,0,0,0,0,0,0,2,         0,1,0,0,0,0,0));

        foreach (vq[i]) begin
            @(negedge clk);
            drive(vq[i].rst, vq[i].flush, vq[i].ev, vq[i].v0, vq[i].a0, vq[i].v1, vq[i].a1, vq[i].dq);
            @(posedge clk);
            #1;
            nvec++;
            check_outs(i, vq[i].c, vq[i].rdy, vq[i].e0v, vq[i].e0a, vq[i].e1v, vq[i].e1a, vq[i].uf);
        end

        // no bypass: an offered group is invisible until the edge
        @(negedge clk);
        drive(0,0,1,1,'h600,1,'h604,0);
        #1;
        nvec++;
        check_outs(100, 0, 1, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        nvec++;
        check_outs(101, 2, 1, 1, 'h600, 1, 'h604, 0);
        for (int g = 1; g < 4; g++) begin
            @(negedge clk);
            drive(0,0,1,1,32'h600 + 32'(8*g),1,32'h604 + 32'(8*g),0);
            @(posedge clk);
        end
        // full queue: a same-cycle dequeue must not open enq_ready
        @(negedge clk);
        drive(0,0,1,1,'h700,1,'h704,2);
        #1;
        nvec++;
        check_outs(102, 8, 0, 1, 'h600, 1, 'h604, 0);
        @(posedge clk);
        #1;
        nvec++;
        check_outs(103, 6, 1, 1, 'h608, 1, 'h60C, 0);

        @(negedge clk);
        drive(0,0,0,0,0,0,0,0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
        $finish;
    end
endmodule
